// File: rtl/ram_dump_tx.sv
// ram_dump_tx: reads WORDS 32-bit RAM words from address 0 and sends every byte (LSB first) as 8N1 UART on tx.
// Latency: start bit 3 cycles after start is accepted; done WORDS*(2+40*CLKS_PER_BIT)+1 cycles after acceptance.
// Backpressure: none; start is ignored while busy, the RAM must answer in 1 cycle; DUMP_CHECKSUM_EN appends an XOR byte.
module ram_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORDS        = 64,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]     TMR_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd6;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd5;
    logic [7:0] csum_q;
`endif

    logic [2:0]    state;
    logic [TW-1:0] bit_tmr;
    logic [3:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic          fetch_cnt;
    logic [31:0]   word_q;
    logic [7:0]    cur_byte;
    logic          tmr_last;
    logic          in_frame;
    logic          tx_nxt;

    assign tmr_last = (bit_tmr == TMR_LAST);

    always_comb begin
        cur_byte = word_q[7:0];
        case (byte_idx)
            2'd1:    cur_byte = word_q[15:8];
            2'd2:    cur_byte = word_q[23:16];
            2'd3:    cur_byte = word_q[31:24];
            default: cur_byte = word_q[7:0];
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle everywhere
    always_comb begin
        tx_nxt   = 1'b1;
        in_frame = 1'b0;
        case (state)
            S_START: begin
                tx_nxt   = 1'b0;
                in_frame = 1'b1;
            end
            S_DATA: begin
                tx_nxt   = cur_byte[bit_idx[2:0]];
                in_frame = 1'b1;
            end
            S_STOP: begin
                tx_nxt   = 1'b1;
                in_frame = 1'b1;
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                in_frame = 1'b1;
                if (bit_idx == 4'd0)
                    tx_nxt = 1'b0;
                else if (bit_idx <= 4'd8)
                    tx_nxt = csum_q[3'(bit_idx - 4'd1)];
                else
                    tx_nxt = 1'b1;
            end
`endif
            default: begin
                tx_nxt   = 1'b1;
                in_frame = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_tmr   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            fetch_cnt <= 1'b0;
            word_q    <= '0;
            mem_addr  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            tx   <= tx_nxt;
            done <= (state == S_FINISH);

            if (in_frame)
                bit_tmr <= tmr_last ? '0 : bit_tmr + TW'(1);
            else
                bit_tmr <= '0;

            case (state)
                S_IDLE: begin
                    // busy drops one cycle after done; only then is a new request taken
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        state     <= S_FETCH;
                        busy      <= 1'b1;
                        mem_addr  <= '0;
                        fetch_cnt <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (fetch_cnt) begin
                        word_q    <= mem_rdata;
                        byte_idx  <= 2'd0;
                        fetch_cnt <= 1'b0;
                        state     <= S_START;
                    end else begin
                        fetch_cnt <= 1'b1;
                    end
                end
                S_START: begin
                    if (tmr_last) begin
                        bit_idx <= 4'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tmr_last) begin
                        if (bit_idx == 4'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_STOP: begin
                    if (tmr_last) begin
`ifdef DUMP_CHECKSUM_EN
                        csum_q <= csum_q ^ cur_byte;
`endif
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_START;
                        end else if (mem_addr != ADDR_LAST) begin
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            fetch_cnt <= 1'b0;
                            state     <= S_FETCH;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            bit_idx <= 4'd0;
                            state   <= S_CSUM;
`else
                            state   <= S_FINISH;
`endif
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (tmr_last) begin
                        if (bit_idx == 4'd9)
                            state <= S_FINISH;
                        else
                            bit_idx <= bit_idx + 4'd1;
                    end
                end
`endif
                S_FINISH: begin
                    mem_addr <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
